// File: rtl/sodor_host_mem_pkg.sv
// Shared types for the Sodor host memory loader: command opcodes, loader
// states and width helpers derived from DATA_WIDTH.
package sodor_host_mem_pkg;

  typedef enum logic [1:0] {
    CMD_SET_ADDR   = 2'd0,
    CMD_WRITE_BYTE = 2'd1,
    CMD_FLUSH      = 2'd2,
    CMD_READ_WORD  = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_ISSUE = 2'd1,
    ST_RD_RSP   = 2'd2
  } loader_state_e;

  function automatic int unsigned mask_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned lane_bits(input int unsigned data_width);
    return (data_width / 8 > 1) ? $clog2(data_width / 8) : 1;
  endfunction

endpackage

// File: rtl/sodor_byte_packer.sv
// Byte staging for the host loader: inserts bytes into lanes of a staging
// word and emits a one-cycle masked write when a word completes or is flushed.
module sodor_byte_packer
  import sodor_host_mem_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned MASK_WIDTH = mask_width(DATA_WIDTH),
  localparam int unsigned LANE_BITS  = lane_bits(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [7:0]            wr_byte,
  input  logic [LANE_BITS-1:0]  lane,
  input  logic                  flush,
  input  logic [31:0]           word_addr,
  output logic                  stage_pending,
  output logic                  hw_en,
  output logic [31:0]           hw_addr,
  output logic [DATA_WIDTH-1:0] hw_data,
  output logic [MASK_WIDTH-1:0] hw_mask
);

  logic [DATA_WIDTH-1:0] stage_data;
  logic [DATA_WIDTH-1:0] ins_data;
  logic [MASK_WIDTH-1:0] stage_mask;
  logic [MASK_WIDTH-1:0] ins_mask;
  logic [MASK_WIDTH-1:0] lane_onehot;
  logic                  last_lane;

  // Staging word as it would look with the incoming byte merged in.
  always_comb begin
    lane_onehot = MASK_WIDTH'(1) << lane;
    ins_data    = stage_data;
    for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
      if (lane_onehot[i]) ins_data[i*8 +: 8] = wr_byte;
    end
    ins_mask  = stage_mask | lane_onehot;
    last_lane = (lane == LANE_BITS'(MASK_WIDTH - 1));
  end

  assign stage_pending = |stage_mask;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_data <= '0;
      stage_mask <= '0;
      hw_en      <= 1'b0;
      hw_addr    <= '0;
      hw_data    <= '0;
      hw_mask    <= '0;
    end else begin
      hw_en <= 1'b0;
      if (wr_en && last_lane) begin
        hw_en      <= 1'b1;
        hw_addr    <= word_addr;
        hw_data    <= ins_data;
        hw_mask    <= ins_mask;
        stage_data <= '0;
        stage_mask <= '0;
      end else if (wr_en) begin
        stage_data <= ins_data;
        stage_mask <= ins_mask;
      end else if (flush) begin
        if (stage_mask != '0) begin
          hw_en   <= 1'b1;
          hw_addr <= word_addr;
          hw_data <= stage_data;
          hw_mask <= stage_mask;
        end
        stage_data <= '0;
        stage_mask <= '0;
      end
    end
  end

endmodule

// File: rtl/sodor_host_mem_loader.sv
// Host loader/readback bridge for the Sodor scratchpad host ports.
// Optional HOST_LOADER_CHECKSUM_EN adds a running byte checksum output.
module sodor_host_mem_loader
  import sodor_host_mem_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned MASK_WIDTH = mask_width(DATA_WIDTH),
  localparam int unsigned LANE_BITS  = lane_bits(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [31:0]           cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [31:0]           hw_addr,
  output logic [DATA_WIDTH-1:0] hw_data,
  output logic [MASK_WIDTH-1:0] hw_mask,
  output logic                  hw_en,
  output logic [31:0]           hr_addr,
  input  logic [DATA_WIDTH-1:0] hr_data,
`ifdef HOST_LOADER_CHECKSUM_EN
  output logic [31:0]           checksum,
`endif
  output logic                  busy
);

  cmd_op_e               op;
  loader_state_e         state, state_nxt;
  logic [31:0]           addr;
  logic [31:0]           word_addr;
  logic [LANE_BITS-1:0]  lane;
  logic                  cmd_fire;
  logic                  wr_en;
  logic                  flush;
  logic                  rd_phase;
  logic                  stage_pending;

  assign op        = cmd_op_e'(cmd_op);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign wr_en     = cmd_fire && (op == CMD_WRITE_BYTE);
  assign flush     = cmd_fire && (op != CMD_WRITE_BYTE);
  assign lane      = addr[LANE_BITS-1:0];
  assign word_addr = addr & ~(32'(MASK_WIDTH) - 32'd1);
  assign busy      = stage_pending || (state != ST_IDLE);

  sodor_byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_byte       (cmd_data[7:0]),
    .lane          (lane),
    .flush         (flush),
    .word_addr     (word_addr),
    .stage_pending (stage_pending),
    .hw_en         (hw_en),
    .hw_addr       (hw_addr),
    .hw_data       (hw_data),
    .hw_mask       (hw_mask)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && op == CMD_READ_WORD) state_nxt = ST_RD_ISSUE;
      end
      ST_RD_ISSUE: begin
        if (rd_phase) state_nxt = ST_RD_RSP;
      end
      ST_RD_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // RD_ISSUE spans two cycles: the first lets any flush write land in memory,
  // the second presents hr_addr and captures the combinational read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr     <= '0;
      rd_phase <= 1'b0;
      hr_addr  <= '0;
      rsp_data <= '0;
    end else begin
      if (cmd_fire && op == CMD_WRITE_BYTE) addr <= addr + 32'd1;
      else if (cmd_fire && op == CMD_SET_ADDR) addr <= cmd_data;

      if (state == ST_RD_ISSUE) rd_phase <= ~rd_phase;
      else                      rd_phase <= 1'b0;

      if (state == ST_RD_ISSUE && !rd_phase) hr_addr <= word_addr;
      if (state == ST_RD_ISSUE && rd_phase)  rsp_data <= hr_data;
    end
  end

`ifdef HOST_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (cmd_fire && op == CMD_WRITE_BYTE) begin
      checksum <= checksum + {24'd0, cmd_data[7:0]};
    end else if (cmd_fire && op == CMD_SET_ADDR) begin
      checksum <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_sodor_host_mem_loader.sv
// Directed bench for sodor_host_mem_loader with a scoreboard of expected
// write pulses and read responses, backed by a small masked memory model.
module tb_sodor_host_mem_loader
  import sodor_host_mem_pkg::*;
;
  localparam int unsigned DW = 32;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    int unsigned due;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [31:0]   cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [31:0]   hw_addr;
  logic [DW-1:0] hw_data;
  logic [3:0]    hw_mask;
  logic          hw_en;
  logic [31:0]   hr_addr;
  logic [DW-1:0] hr_data;
  logic          busy;
`ifdef HOST_LOADER_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  logic [DW-1:0] mem [0:255];
  wr_t           exp_wr_q[$];
  logic [31:0]   exp_rsp_q[$];
  int unsigned   cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  sodor_host_mem_loader #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .hw_addr   (hw_addr),
    .hw_data   (hw_data),
    .hw_mask   (hw_mask),
    .hw_en     (hw_en),
    .hr_addr   (hr_addr),
    .hr_data   (hr_data),
`ifdef HOST_LOADER_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .busy      (busy)
  );

  assign hr_data = mem[hr_addr[9:2]];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (hw_en) begin
      for (int b = 0; b < 4; b++)
        if (hw_mask[b]) mem[hw_addr[9:2]][b*8 +: 8] <= hw_data[b*8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs are applied at the preceding negedge, outputs checked at the next.
  task automatic step();
    wr_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (exp_wr_q.size() > 0 && exp_wr_q[0].due == cyc) begin
      e = exp_wr_q.pop_front();
      chk("hw_en", 64'(hw_en), 64'(1));
      chk("hw_addr", 64'(hw_addr), 64'(e.addr));
      chk("hw_data", 64'(hw_data), 64'(e.data));
      chk("hw_mask", 64'(hw_mask), 64'(e.mask));
    end else if (hw_en !== 1'b0) begin
      chk("hw_en_unexpected", 64'(hw_en), 64'(0));
    end
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    wr_t e;
    e.addr = a; e.data = d; e.mask = m; e.due = cyc + 1;
    exp_wr_q.push_back(e);
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rd_exp;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    step();
    step();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_data", 64'(rsp_data), 64'(0));
    chk("rst_hw_en", 64'(hw_en), 64'(0));
    chk("rst_hw_addr", 64'(hw_addr), 64'(0));
    chk("rst_hw_data", 64'(hw_data), 64'(0));
    chk("rst_hw_mask", 64'(hw_mask), 64'(0));
    chk("rst_hr_addr", 64'(hr_addr), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
`ifdef HOST_LOADER_CHECKSUM_EN
    chk("rst_checksum", 64'(checksum), 64'(0));
`endif
    rst_n = 1'b1;

    // Full word at full rate
    send(CMD_SET_ADDR, 32'h100);
    chk("set_busy", 64'(busy), 64'(0));
    send(CMD_WRITE_BYTE, 32'h11);
    chk("wb_ready1", 64'(cmd_ready), 64'(1));
    chk("wb_busy1", 64'(busy), 64'(1));
    send(CMD_WRITE_BYTE, 32'h22);
    chk("wb_ready2", 64'(cmd_ready), 64'(1));
    send(CMD_WRITE_BYTE, 32'h33);
    chk("wb_ready3", 64'(cmd_ready), 64'(1));
    push_wr(32'h100, 32'h44332211, 4'b1111);
    send(CMD_WRITE_BYTE, 32'h44);
    chk("wb_ready4", 64'(cmd_ready), 64'(1));
    chk("full_busy", 64'(busy), 64'(0));
    step();

    // Partial word flush, then empty flush
    send(CMD_SET_ADDR, 32'h202);
    send(CMD_WRITE_BYTE, 32'hAA);
    push_wr(32'h200, 32'h00AA0000, 4'b0100);
    send(CMD_FLUSH, 32'h0);
    send(CMD_FLUSH, 32'h0);
    step();

    // Read after partial staging returns the flushed data
    send(CMD_SET_ADDR, 32'h300);
    send(CMD_WRITE_BYTE, 32'h5A);
    push_wr(32'h300, 32'h0000005A, 4'b0001);
    exp_rsp_q.push_back(32'h0000005A);
    send(CMD_READ_WORD, 32'h0);
    chk("rd_e1_ready", 64'(cmd_ready), 64'(0));
    chk("rd_e1_valid", 64'(rsp_valid), 64'(0));
    step();
    chk("rd_e2_hr_addr", 64'(hr_addr), 64'(32'h300));
    chk("rd_e2_valid", 64'(rsp_valid), 64'(0));
    step();
    chk("rd_e3_valid", 64'(rsp_valid), 64'(1));
    rd_exp = exp_rsp_q.pop_front();
    chk("rd_e3_data", 64'(rsp_data), 64'(rd_exp));
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rd_hold_valid", 64'(rsp_valid), 64'(1));
      chk("rd_hold_data", 64'(rsp_data), 64'(rd_exp));
      chk("rd_hold_ready", 64'(cmd_ready), 64'(0));
      chk("rd_hold_busy", 64'(busy), 64'(1));
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rd_done_valid", 64'(rsp_valid), 64'(0));
    chk("rd_done_ready", 64'(cmd_ready), 64'(1));
    chk("rd_done_busy", 64'(busy), 64'(0));
    chk("rd_hr_addr_hold", 64'(hr_addr), 64'(32'h300));

    // Address wrap across 2^32
    send(CMD_SET_ADDR, 32'hFFFF_FFFF);
    push_wr(32'hFFFF_FFFC, 32'h01000000, 4'b1000);
    send(CMD_WRITE_BYTE, 32'h01);
    send(CMD_WRITE_BYTE, 32'h02);
    push_wr(32'h0, 32'h00000002, 4'b0001);
    send(CMD_FLUSH, 32'h0);
    step();

    // Reset with staged bytes discards them
    send(CMD_SET_ADDR, 32'h500);
    send(CMD_WRITE_BYTE, 32'h77);
    send(CMD_WRITE_BYTE, 32'h88);
    chk("pre_rst_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_ready", 64'(cmd_ready), 64'(1));
    send(CMD_FLUSH, 32'h0);
    step();
    send(CMD_WRITE_BYTE, 32'h99);
    push_wr(32'h0, 32'h00000099, 4'b0001);
    send(CMD_FLUSH, 32'h0);
    step();

`ifdef HOST_LOADER_CHECKSUM_EN
    send(CMD_SET_ADDR, 32'h600);
    chk("cks_clear0", 64'(checksum), 64'(0));
    send(CMD_WRITE_BYTE, 32'hFF);
    send(CMD_WRITE_BYTE, 32'hFF);
    send(CMD_WRITE_BYTE, 32'h02);
    chk("cks_sum", 64'(checksum), 64'(32'h200));
    push_wr(32'h600, 32'h0002FFFF, 4'b0111);
    send(CMD_SET_ADDR, 32'h0);
    chk("cks_clear", 64'(checksum), 64'(0));
    step();
`endif

    chk("wr_queue_drained", 64'(exp_wr_q.size()), 64'(0));
    chk("rsp_queue_drained", 64'(exp_rsp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
